// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, conversion FSM states and the double-dabble add-3 step
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return n >= 4'd5 ? n + 4'd3 : n;
  endfunction
endpackage

// File: rtl/seg7_digit_decode.sv
// seg7_digit_decode: 4-bit BCD digit to active-high 7-segment pattern (a=bit0)
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end
endmodule

// File: rtl/bin2seg_encoder.sv
// bin2seg_encoder: binary value to two-digit 7-segment word via sequential double-dabble
module bin2seg_encoder
  import seg7_pkg::*;
#(
  parameter int IN_W           = 7,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit BLANK_LEAD     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] value,
  output logic [13:0]     both7seg,
  output logic            out_valid
);
  localparam logic [13:0] POL = {14{SEG_ACTIVE_LOW}};

  state_t          state;
  logic [IN_W-1:0] shreg;
  logic [11:0]     bcd;
  logic [11:0]     adj;
  logic [3:0]      cnt;
  logic [6:0]      tens_raw;
  logic [6:0]      units_raw;
  logic [6:0]      tens_seg;
  logic [6:0]      units_seg;

  assign in_ready = state == IDLE;
  assign adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

  seg7_digit_decode u_tens  (.digit(bcd[7:4]), .seg(tens_raw));
  seg7_digit_decode u_units (.digit(bcd[3:0]), .seg(units_raw));

  // hundreds nibble only flags overflow; it never reaches a digit
  always_comb begin
    tens_seg  = bcd[11:8] != 4'd0 ? SEG_DASH :
                (bcd[7:4] == 4'd0 && BLANK_LEAD) ? SEG_BLANK : tens_raw;
    units_seg = bcd[11:8] != 4'd0 ? SEG_DASH : units_raw;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bcd       <= '0;
      cnt       <= '0;
      both7seg  <= POL;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          shreg <= value;
          bcd   <= '0;
          cnt   <= 4'(IN_W - 1);
          state <= SHIFT;
        end
        SHIFT: begin
          {bcd, shreg} <= {adj, shreg} << 1;
          cnt          <= cnt - 4'd1;
          if (cnt == 4'd0) state <= ENCODE;
        end
        ENCODE: begin
          both7seg  <= {tens_seg, units_seg} ^ POL;
          out_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bin2seg_encoder.sv
// tb_bin2seg_encoder: three parameter variants driven in lockstep, checked by a queued reference model
module tb_bin2seg_encoder;
  localparam int IN_W = 7;
  localparam int LAT  = IN_W + 1;
  localparam int PER  = IN_W + 2;
  localparam logic [6:0] DIG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam bit BL [3] = '{1'b1, 1'b0, 1'b1};
  localparam bit AL [3] = '{1'b0, 1'b0, 1'b1};

  typedef struct {
    int               acc;
    logic [2:0][13:0] e;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            in_valid = 1'b0;
  logic [IN_W-1:0] value = '0;
  logic [13:0]     seg [3];
  logic            ov  [3];
  logic            rdy [3];

  exp_t        q[$];
  exp_t        x;
  exp_t        n;
  logic [13:0] hold [3];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          b2b = 1'b0;
  int          last_acc = -1;

  bin2seg_encoder #(.IN_W(IN_W), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEAD(1'b1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .value(value), .both7seg(seg[0]), .out_valid(ov[0]));
  bin2seg_encoder #(.IN_W(IN_W), .SEG_ACTIVE_LOW(1'b0), .BLANK_LEAD(1'b0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .value(value), .both7seg(seg[1]), .out_valid(ov[1]));
  bin2seg_encoder #(.IN_W(IN_W), .SEG_ACTIVE_LOW(1'b1), .BLANK_LEAD(1'b1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[2]),
    .value(value), .both7seg(seg[2]), .out_valid(ov[2]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [13:0] model(int v, bit bl, bit al);
    logic [6:0] t, u;
    if (v > 99) begin
      t = 7'h40;
      u = 7'h40;
    end else begin
      t = (v / 10 == 0 && bl) ? 7'h00 : DIG[v / 10];
      u = DIG[v % 10];
    end
    return al ? ~{t, u} : {t, u};
  endfunction

  function automatic logic [13:0] blank(int i);
    return AL[i] ? 14'h3FFF : 14'h0000;
  endfunction

  task automatic chk(string name, int i, logic [13:0] act, logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, i, act, exp, cyc);
    end
  endtask

  task automatic chk_i(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // monitor + accept observer
  always @(negedge clk) begin
    if (rst) begin
      if (ov[0] || ov[1] || ov[2]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious out_valid at cycle %0d", cyc);
        end else begin
          x = q.pop_front();
          chk_i("latency", cyc, x.acc + LAT);
          for (int i = 0; i < 3; i++) begin
            chk("out_valid", i, 14'(ov[i]), 14'd1);
            chk("both7seg", i, seg[i], x.e[i]);
            hold[i] = x.e[i];
          end
        end
      end else begin
        for (int i = 0; i < 3; i++) chk("hold", i, seg[i], hold[i]);
      end
      if (in_valid && rdy[0]) begin
        n.acc = cyc + 1;
        for (int i = 0; i < 3; i++) n.e[i] = model(int'(value), BL[i], AL[i]);
        q.push_back(n);
        if (b2b && last_acc >= 0) chk_i("b2b_period", n.acc - last_acc, PER);
        last_acc = n.acc;
      end
    end
  end

  task automatic send(int v);
    int k = 0;
    while (!rdy[0] && k < 4 * PER) begin
      @(posedge clk); #1;
      k++;
    end
    if (!rdy[0]) begin
      checks++;
      errors++;
      $display("FAIL ready timeout at cycle %0d", cyc);
      return;
    end
    in_valid = 1'b1;
    value = IN_W'(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    value = IN_W'($urandom);
  endtask

  initial begin
    int dir [6] = '{42, 7, 0, 99, 100, 127};
    for (int i = 0; i < 3; i++) hold[i] = blank(i);
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("reset_seg", i, seg[i], blank(i));
      chk("reset_ov", i, 14'(ov[i]), 14'd0);
    end
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("reset_ready", i, 14'(rdy[i]), 14'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send(dir[i]);
    for (int i = 0; i < 20; i++) begin
      send(int'($urandom_range(0, 127)));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    while (!rdy[0]) begin @(posedge clk); #1; end
    b2b = 1'b1;
    last_acc = -1;
    in_valid = 1'b1;
    repeat (5 * PER) begin
      value = IN_W'($urandom_range(0, 127));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    b2b = 1'b0;
    repeat (2 * PER) @(posedge clk);
    #1;
    send(55);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    for (int i = 0; i < 3; i++) hold[i] = blank(i);
    #1;
    for (int i = 0; i < 3; i++) chk("abort_blank", i, seg[i], blank(i));
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) chk("abort_ready", i, 14'(rdy[i]), 14'd1);
    @(posedge clk); #1;
    send(12);
    for (int i = 0; i < 5; i++) send(int'($urandom_range(0, 127)));
    repeat (3 * PER) @(posedge clk);
    #1;
    chk_i("drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
